// File: rtl/shift_arbiter.sv
// shift_arbiter
//   Two-port arbiter in front of one shared 32-bit barrel shifter, with a
//   single-entry result register and per-port grant counters.
//
//   Parameters
//     RR_EN  1 = round-robin between ports, 0 = fixed priority (port 0 wins)
//     CNT_W  width of each saturating grant counter
//
//   Ports
//     clk, rst_n                 clock, async active-low reset
//     reqN_valid / reqN_ready    request handshake for port N (ready is comb.)
//     reqN_a, reqN_shamt,        operand, shift amount and shift type
//     reqN_type                  (00 lsr, 01 lsl, 10 asr, 11 pass)
//     rsp_valid / rsp_ready      result handshake
//     rsp_data, rsp_port         result and owning port index
//     grant0_cnt, grant1_cnt     accepted-request counters (saturating)
//
//   Output FSM
//     state | meaning
//     EMPTY | result register holds nothing, rsp_valid = 0
//     FULL  | result register holds a result, rsp_valid = 1
module shift_arbiter #(
  parameter int RR_EN = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [4:0]       req0_shamt,
  input  logic [1:0]       req0_type,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [4:0]       req1_shamt,
  input  logic [1:0]       req1_type,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_port,
  output logic [CNT_W-1:0] grant0_cnt,
  output logic [CNT_W-1:0] grant1_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t      state;
  logic        last_grant;
  logic        slot_free;
  logic        win0;
  logic        grant0;
  logic        grant1;
  logic [31:0] sh_a;
  logic [4:0]  sh_amt;
  logic [1:0]  sh_type;
  logic [31:0] sh_res;

  // The slot is free if empty, or if the held result leaves this same cycle.
  always_comb begin
    slot_free = (state == EMPTY) || rsp_ready;
  end

  // win0: port 0 would win if the slot were free. Under contention the
  // round-robin pointer favours the port that did not win last time.
  always_comb begin
    win0 = 1'b0;
    if (req0_valid && req1_valid) begin
      win0 = (RR_EN != 0) ? last_grant : 1'b1;
    end else begin
      win0 = req0_valid;
    end
    // rst_n gating keeps both ready lines low while reset is held.
    grant0 = rst_n && slot_free && win0;
    grant1 = rst_n && slot_free && req1_valid && !win0;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Single shared shifter, operands muxed from the granted port.
  always_comb begin
    sh_a    = grant1 ? req1_a     : req0_a;
    sh_amt  = grant1 ? req1_shamt : req0_shamt;
    sh_type = grant1 ? req1_type  : req0_type;
    case (sh_type)
      2'b00:   sh_res = sh_a >> sh_amt;
      2'b01:   sh_res = sh_a << sh_amt;
      2'b10:   sh_res = $unsigned($signed(sh_a) >>> sh_amt);
      default: sh_res = sh_a;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      rsp_data   <= '0;
      rsp_port   <= 1'b0;
      last_grant <= 1'b1;
      grant0_cnt <= '0;
      grant1_cnt <= '0;
    end else begin
      if (grant0 || grant1) begin
        state      <= FULL;
        rsp_data   <= sh_res;
        rsp_port   <= grant1;
        last_grant <= grant1;
      end else if (rsp_ready) begin
        state <= EMPTY;
      end
      if (grant0 && (grant0_cnt != '1)) begin
        grant0_cnt <= grant0_cnt + CNT_W'(1);
      end
      if (grant1 && (grant1_cnt != '1)) begin
        grant1_cnt <= grant1_cnt + CNT_W'(1);
      end
    end
  end

  assign rsp_valid = (state == FULL);

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, rsp_ready;
  logic [31:0] req0_a, req1_a;
  logic [4:0]  req0_shamt, req1_shamt;
  logic [1:0]  req0_type, req1_type;

  logic        req0_ready, req1_ready, rsp_valid, rsp_port;
  logic [31:0] rsp_data;
  logic [15:0] grant0_cnt, grant1_cnt;

  // second instance: fixed priority, 2-bit counters, same stimulus
  logic        fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_port;
  logic [31:0] fp_rsp_data;
  logic [1:0]  fp_grant0_cnt, fp_grant1_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        port;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  shift_arbiter #(.RR_EN(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_shamt(req0_shamt), .req0_type(req0_type),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_shamt(req1_shamt), .req1_type(req1_type),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_port(rsp_port), .grant0_cnt(grant0_cnt), .grant1_cnt(grant1_cnt)
  );

  shift_arbiter #(.RR_EN(0), .CNT_W(2)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_a(req0_a),
    .req0_shamt(req0_shamt), .req0_type(req0_type),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_a(req1_a),
    .req1_shamt(req1_shamt), .req1_type(req1_type),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(fp_rsp_data),
    .rsp_port(fp_rsp_port), .grant0_cnt(fp_grant0_cnt), .grant1_cnt(fp_grant1_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic port, input logic [31:0] data);
    exp_q.push_back('{port: port, data: data});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [31:0] a, input logic [4:0] sh, input logic [1:0] t);
    req0_valid = v; req0_a = a; req0_shamt = sh; req0_type = t;
  endtask

  task automatic set1(input logic v, input logic [31:0] a, input logic [4:0] sh, input logic [1:0] t);
    req1_valid = v; req1_a = a; req1_shamt = sh; req1_type = t;
  endtask

  // Monitor: every accepted response is popped and compared.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got port %0d data 0x%08h, expected none", rsp_port, rsp_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checks++;
          if (rsp_data !== e.data || rsp_port !== e.port) begin
            errors++;
            $display("FAIL rsp: got port %0d data 0x%08h expected port %0d data 0x%08h",
                     rsp_port, rsp_data, e.port, e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // port 1 type vectors: a, shamt, type, expected
  logic [31:0] tv_a   [9] = '{32'h0000000F, 32'h0000000F, 32'h0000000F, 32'h0000000F,
                              32'h0000000F, 32'h0000000F, 32'h0000000F, 32'h80000000, 32'h80000000};
  logic [4:0]  tv_sh  [9] = '{5'd31, 5'd31, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd31};
  logic [1:0]  tv_t   [9] = '{2'b01, 2'b00, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b00};
  logic [31:0] tv_exp [9] = '{32'h80000000, 32'h00000000, 32'h0000000F, 32'h0000000F,
                              32'h0000000F, 32'h0000000F, 32'h0000000F, 32'hFFFFFFFF, 32'h00000001};

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    set0(1'b1, 32'h1, 5'd0, 2'b11);
    set1(1'b1, 32'h1, 5'd0, 2'b11);
    #3;
    // reset state
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_port", {31'b0, rsp_port}, 32'h0);
    chk("rst_cnt0", {16'b0, grant0_cnt}, 32'h0);
    chk("rst_cnt1", {16'b0, grant1_cnt}, 32'h0);
    chk("rst_ready", {30'b0, req0_ready, req1_ready}, 32'h0);
    step(); step();
    set0(1'b0, 32'h0, 5'd0, 2'b00);
    set1(1'b0, 32'h0, 5'd0, 2'b00);
    rst_n = 1'b1;
    step();

    // single op, arithmetic right
    rsp_ready = 1'b1;
    set0(1'b1, 32'h80000010, 5'd4, 2'b10);
    push_exp(1'b0, 32'hF8000001);
    mid();
    chk("single_ready0", {31'b0, req0_ready}, 32'h1);
    step();
    set0(1'b0, 32'h0, 5'd0, 2'b00);
    chk("single_valid", {31'b0, rsp_valid}, 32'h1);
    chk("single_data", rsp_data, 32'hF8000001);
    chk("single_port", {31'b0, rsp_port}, 32'h0);
    chk("single_cnt0", {16'b0, grant0_cnt}, 32'h1);
    step();
    chk("single_empty", {31'b0, rsp_valid}, 32'h0);

    // shift types, back-to-back on port 1
    for (int i = 0; i < 9; i++) begin
      set1(1'b1, tv_a[i], tv_sh[i], tv_t[i]);
      push_exp(1'b1, tv_exp[i]);
      mid();
      chk($sformatf("type_ready1_%0d", i), {31'b0, req1_ready}, 32'h1);
      step();
      if (i == 4) chk("sat_cnt1_after5", {30'b0, fp_grant1_cnt}, 32'h3);
    end
    set1(1'b0, 32'h0, 5'd0, 2'b00);
    chk("type_cnt1", {16'b0, grant1_cnt}, 32'd9);
    chk("sat_cnt1_final", {30'b0, fp_grant1_cnt}, 32'h3);
    step();

    // contention: last grant was port 1, so 0,1,0,1
    set0(1'b1, 32'h00000001, 5'd1, 2'b01);
    set1(1'b1, 32'h00000100, 5'd4, 2'b00);
    for (int i = 0; i < 4; i++) begin
      push_exp(i[0], i[0] ? 32'h00000010 : 32'h00000002);
      mid();
      chk($sformatf("rr_ready_%0d", i), {30'b0, req1_ready, req0_ready}, i[0] ? 32'h2 : 32'h1);
      chk($sformatf("fp_ready_%0d", i), {30'b0, fp_req1_ready, fp_req0_ready}, 32'h1);
      step();
    end
    set0(1'b0, 32'h0, 5'd0, 2'b00);
    set1(1'b0, 32'h0, 5'd0, 2'b00);
    step();

    // backpressure
    set0(1'b1, 32'h12345678, 5'd8, 2'b00);
    push_exp(1'b0, 32'h00123456);
    step();
    set0(1'b0, 32'h0, 5'd0, 2'b00);
    rsp_ready = 1'b0;
    set1(1'b1, 32'h7FFF0000, 5'd16, 2'b10);
    for (int i = 0; i < 3; i++) begin
      mid();
      chk($sformatf("bp_ready1_%0d", i), {31'b0, req1_ready}, 32'h0);
      chk($sformatf("bp_data_%0d", i), rsp_data, 32'h00123456);
      chk($sformatf("bp_valid_%0d", i), {31'b0, rsp_valid}, 32'h1);
      step();
    end
    rsp_ready = 1'b1;
    push_exp(1'b1, 32'h00007FFF);
    mid();
    chk("bp_release_ready1", {31'b0, req1_ready}, 32'h1);
    step();
    set1(1'b0, 32'h0, 5'd0, 2'b00);
    step();
    chk("empty_valid", {31'b0, rsp_valid}, 32'h0);
    set0(1'b0, 32'hDEADBEEF, 5'd3, 2'b01);
    step();
    chk("empty_hold_data", rsp_data, 32'h00007FFF);
    chk("empty_hold_port", {31'b0, rsp_port}, 32'h1);

    // reset while FULL
    rsp_ready = 1'b0;
    set1(1'b1, 32'h00000001, 5'd3, 2'b01);
    step();
    set1(1'b0, 32'h0, 5'd0, 2'b00);
    chk("pre_rst_valid", {31'b0, rsp_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, rsp_valid}, 32'h0);
    chk("mid_rst_data", rsp_data, 32'h0);
    chk("mid_rst_cnt", {grant1_cnt, grant0_cnt}, 32'h0);
    chk("mid_rst_fp_cnt", {28'b0, fp_grant1_cnt, fp_grant0_cnt}, 32'h0);
    step();
    #2;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    set0(1'b1, 32'h0000ABCD, 5'd4, 2'b01);
    set1(1'b1, 32'h0000FFFF, 5'd4, 2'b00);
    push_exp(1'b0, 32'h000ABCD0);
    mid();
    chk("post_rst_ready", {30'b0, req1_ready, req0_ready}, 32'h1);
    step();
    set0(1'b0, 32'h0, 5'd0, 2'b00);
    set1(1'b0, 32'h0, 5'd0, 2'b00);
    chk("post_rst_cnt", {grant1_cnt, grant0_cnt}, 32'h00000001);
    step();
    step();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d pending responses expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
